ext_data_receiver: RTL and testbench
====================================

// Module: ext_data_receiver
// PURPOSE
//  Receiving end of the external FPGA-to-FPGA UART link. Deserialises one data frame
//  (start, 8 data bits LSB first, stop) from the peer's data transmitter, presents the
//  byte, and answers every good frame with the ACK byte on a separate UART tx wire.
//  Sits between the GPIO receive/ack pins and the ext-com display/increment logic in top.
// PARAMETERS
//  UART_WIDTH     8            data bits per frame
//  CLK_FREQ       50_000_000   clk frequency, Hz
//  UART_BAUD_RATE 230_400      line rate, both directions
//  UART_ACK       8'b11001100  byte returned for every good frame
// PORTS
//  clk        in   1           system clock
//  rst        in   1           synchronous, active-high reset
//  rx         in   1           serial data from peer (idle high, asynchronous)
//  tx         out  1           serial ACK to peer (idle high)
//  data_out   out  UART_WIDTH  last good byte; held until next good frame
//  data_valid out  1           1-cycle pulse: data_out updated
//  frame_err  out  1           1-cycle pulse: stop bit sampled low
//  ack_busy   out  1           high while ACK is being serialised or is pending
// BEHAVIOUR
//  - Reset: tx=1, data_out=0, data_valid=0, frame_err=0, ack_busy=0, both FSMs IDLE,
//    ack_pending=0. Reset mid-frame/mid-ACK aborts immediately; tx high next cycle.
//  - BAUD_CNT = CLK_FREQ/UART_BAUD_RATE (integer, 217 at defaults); HALF = BAUD_CNT/2.
//  - rx passes a 2-flop synchroniser; all decisions use the synchronised value.
//  - RX FSM: IDLE -(rx=0)-> START; START: after HALF cycles sample; rx=1 -> IDLE (glitch,
//    no output), rx=0 -> DATA. DATA: sample every BAUD_CNT cycles, shift in LSB first,
//    UART_WIDTH samples -> STOP. STOP: sample after BAUD_CNT; rx=1 -> data_out<=shift,
//    data_valid=1 next cycle, set ack_pending, -> IDLE; rx=0 -> frame_err pulse, no ACK,
//    -> BREAK; BREAK waits for rx=1 then -> IDLE.
//  - TX FSM: IDLE -(ack_pending)-> START (clears ack_pending same cycle), drives 0 for
//    BAUD_CNT; DATA drives UART_ACK LSB first, BAUD_CNT each; STOP drives 1 for BAUD_CNT;
//    -> IDLE. First start-bit cycle is the cycle after data_valid.
//  - RX and TX run concurrently (full duplex): a new frame may arrive during an ACK.
//    ack_pending is 1 deep; a good frame while ack_pending=1 keeps it set (one ACK
//    covers both; peer retransmits on timeout). data_valid still pulses per good frame.
//  - Retransmitted duplicates are not filtered; each good frame yields data_valid + ACK.
//  - ack_busy = ack_pending | (TX FSM != IDLE).
//  - Counters sized $clog2(BAUD_CNT+1); bit index $clog2(UART_WIDTH+1); no wrap ever
//    observable (counters reload on every state change).
// STRUCTURE
//  - ext_com_pkg: UART_ACK default, rx_state_t {IDLE,START,DATA,STOP,BREAK},
//    tx_state_t {IDLE,START,DATA,STOP}, function baud_cnt(clk_freq, baud).
//  - One sub-module: ext_uart_tx (generic byte serialiser: start/byte in, busy, tx out),
//    instantiated with byte tied to UART_ACK.
// TESTING (bit time 4340 ns at defaults; driver/monitor mirror the peer FPGA)
//  - Frame 8'b00111011 -> data_out=8'h3B, data_valid one pulse, tx returns 8'hCC,
//    start bit begins 1 clk after data_valid; frame_err never pulses.
//  - rx low 1 us then high -> no data_valid, no frame_err, tx stays 1, RX back to IDLE.
//  - Frame 8'h2F with stop bit 0, then rx held low 3 bit times, then 8'h3F -> frame_err
//    one pulse, no ACK for 8'h2F; 8'h3F -> data_valid + one 8'hCC.
//  - 8'h2F then 8'h3F back-to-back (second starts during ACK) -> two data_valid,
//    data_out ends 8'h3F, exactly two 8'hCC frames on tx, serialised without overlap.
//  - Same byte 8'h05 sent twice (peer retransmit) -> two data_valid, two ACKs.
//  - rst asserted at data bit 4 of an incoming frame and mid-ACK -> tx=1, data_out=0,
//    no data_valid for the aborted frame; next full frame 8'hA5 received normally.

Source files
------------

// File: rtl/ext_com_pkg.sv
// Shared types and helpers for the external FPGA-to-FPGA UART link.
package ext_com_pkg;

  // Byte returned to the peer for every good frame.
  localparam logic [7:0] UART_ACK_DEF = 8'b11001100;

  // Receiver states. BREAK holds off after a low stop bit until the line idles.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Serialiser states.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Clock cycles per bit (integer division, 217 at 50 MHz / 230400 baud).
  function automatic int baud_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/ext_uart_tx.sv
// Generic byte serialiser: start bit, WIDTH data bits LSB first, stop bit.
// Handshake: a byte is accepted when start is high while busy is low; busy stays
// high from the following cycle until the stop bit has been fully driven.
module ext_uart_tx
  import ext_com_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int BAUD_CNT = 217
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             tx,
  output tx_state_t        state
);

  localparam int CW = $clog2(BAUD_CNT + 1);
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_CNT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  tx_state_t        state_q;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] shreg;

  // Serialiser FSM; tx is registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (start) begin
            state_q <= TX_START;
            tx      <= 1'b0;
            shreg   <= data;
          end
        end
        TX_START: begin
          if (cnt == BIT_LAST) begin
            state_q <= TX_DATA;
            cnt     <= '0;
            idx     <= '0;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state_q <= TX_STOP;
              tx      <= 1'b1;
            end else begin
              idx   <= idx + IW'(1);
              tx    <= shreg[0];
              shreg <= shreg >> 1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (cnt == BIT_LAST) begin
            state_q <= TX_IDLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state_q <= TX_IDLE;
          tx      <= 1'b1;
        end
      endcase
    end
  end

  assign busy  = (state_q != TX_IDLE);
  assign state = state_q;

endmodule

// File: rtl/ext_data_receiver.sv
// Receiving end of the external UART link: deserialises frames from the peer,
// presents each good byte and answers it with the ACK byte on a separate tx wire.
// RX and TX run independently (full duplex); a single pending flag bridges them,
// so a good frame arriving while an ACK is still pending is covered by that ACK.
module ext_data_receiver
  import ext_com_pkg::*;
#(
  parameter int                    UART_WIDTH     = 8,
  parameter int                    CLK_FREQ       = 50_000_000,
  parameter int                    UART_BAUD_RATE = 230_400,
  parameter logic [UART_WIDTH-1:0] UART_ACK       = UART_ACK_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  tx,
  output logic [UART_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  ack_busy
);

  localparam int BAUD = baud_cnt(CLK_FREQ, UART_BAUD_RATE);
  localparam int HALF = BAUD / 2;
  localparam int CW   = $clog2(BAUD + 1);
  localparam int IW   = $clog2(UART_WIDTH + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_WIDTH - 1);

  logic                  rx_meta;
  logic                  rx_sync;
  rx_state_t             rx_state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [UART_WIDTH-1:0] shreg;
  logic                  stop_good;
  logic                  ack_pending;
  logic                  ack_start;
  logic                  tx_busy;
  tx_state_t             tx_state;

  // Two-flop synchroniser for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Stop bit sampled high: the frame is good.
  assign stop_good = (rx_state == RX_STOP) && (cnt == BIT_LAST) && rx_sync;

  // Receive FSM: mid-bit sampling, LSB first, registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            idx      <= '0;
            // A start bit that is gone by mid-bit was a glitch.
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[UART_WIDTH-1:1]};
            if (idx == IDX_LAST) rx_state <= RX_STOP;
            else idx <= idx + IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              rx_state   <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              rx_state  <= RX_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_BREAK: begin
          cnt <= '0;
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A pending ACK is launched as soon as the serialiser is free.
  assign ack_start = ack_pending && !tx_busy;

  // One-deep ACK request; a new good frame wins over a same-cycle launch.
  always_ff @(posedge clk) begin
    if (rst) ack_pending <= 1'b0;
    else     ack_pending <= (ack_pending && !ack_start) || stop_good;
  end

  ext_uart_tx #(
    .WIDTH    (UART_WIDTH),
    .BAUD_CNT (BAUD)
  ) u_ack_tx (
    .clk   (clk),
    .rst   (rst),
    .start (ack_start),
    .data  (UART_ACK),
    .busy  (tx_busy),
    .tx    (tx),
    .state (tx_state)
  );

  assign ack_busy = ack_pending || tx_busy;

endmodule

// File: tb/tb_ext_data_receiver.sv
// Bench for ext_data_receiver: a peer-side driver on rx, monitors for data_valid,
// frame_err and ACK frames on tx, and a queue-based model of expected bytes.
`timescale 1ns/1ps
module tb_ext_data_receiver;

  localparam int BAUD = 50_000_000 / 230_400;
  localparam int HALF = BAUD / 2;
  localparam logic [7:0] ACK = 8'hCC;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       tx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       ack_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // monitor state
  logic [7:0] dv_q[$];
  int         dv_cyc_q[$];
  logic [7:0] ack_q[$];
  int         ack_start_q[$];
  int         fe_cnt     = 0;
  int         tx_low_cnt = 0;
  int         stop_bad   = 0;
  logic [7:0] ack_byte;

  // model state
  logic [7:0] exp_q[$];
  int         exp_fe;

  ext_data_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .tx         (tx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .ack_busy   (ack_busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation time limit reached, got cyc=%0d need finish", cyc);
    $fatal(1, "watchdog");
  end

  // output monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_q.push_back(data_out);
      dv_cyc_q.push_back(cyc);
    end
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (tx === 1'b0) tx_low_cnt <= tx_low_cnt + 1;
  end

  // ACK decoder acting as the peer's receiver
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && rst === 1'b0) begin
        ack_start_q.push_back(cyc);
        repeat (HALF) @(negedge clk);
        if (tx !== 1'b0) stop_bad = stop_bad + 1;
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          ack_byte[i] = tx;
        end
        repeat (BAUD) @(negedge clk);
        if (tx !== 1'b1) stop_bad = stop_bad + 1;
        ack_q.push_back(ack_byte);
      end
    end
  end

  // driver tasks
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BAUD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (ack_busy !== 1'b0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    total++;
    if (n >= 6000) begin
      bad++;
      $display("FAIL %s_idle_timeout: ack_busy=%b after %0d cycles, need 0", name, ack_busy, n);
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b need 1", tx); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h need 00", data_out); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid: got %b need 0", data_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b need 0", frame_err); end
    total++; if (ack_busy !== 1'b0) begin bad++; $display("FAIL reset_ack_busy: got %b need 0", ack_busy); end
    rst = 1'b0;
    idle_bits(1);
  endtask

  task automatic test_basic();
    int dv0, ak0, fe0;
    dv0 = dv_q.size(); ak0 = ack_q.size(); fe0 = fe_cnt;
    send_frame(8'b00111011, 1'b1);
    idle_bits(1);
    wait_idle("basic");
    total++; if (dv_q.size() - dv0 !== 1) begin bad++; $display("FAIL basic_dv_count: got %0d need 1", dv_q.size() - dv0); end
    if (dv_q.size() > dv0) begin
      total++; if (dv_q[dv0] !== 8'h3B) begin bad++; $display("FAIL basic_dv_byte: got %h need 3b", dv_q[dv0]); end
    end
    total++; if (data_out !== 8'h3B) begin bad++; $display("FAIL basic_data_out: got %h need 3b", data_out); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL basic_frame_err: got %0d need 0", fe_cnt - fe0); end
    total++; if (ack_q.size() - ak0 !== 1) begin bad++; $display("FAIL basic_ack_count: got %0d need 1", ack_q.size() - ak0); end
    if (ack_q.size() > ak0) begin
      total++; if (ack_q[ak0] !== ACK) begin bad++; $display("FAIL basic_ack_byte: got %h need cc", ack_q[ak0]); end
    end
    if (dv_q.size() > dv0 && ack_start_q.size() > ak0) begin
      total++;
      if (ack_start_q[ak0] - dv_cyc_q[dv0] !== 1) begin
        bad++; $display("FAIL basic_ack_latency: got %0d need 1", ack_start_q[ak0] - dv_cyc_q[dv0]);
      end
    end
    total++; if (stop_bad !== 0) begin bad++; $display("FAIL basic_ack_framing: got %0d need 0", stop_bad); end
  endtask

  task automatic test_glitch();
    int dv0, fe0, tl0;
    dv0 = dv_q.size(); fe0 = fe_cnt; tl0 = tx_low_cnt;
    rx = 1'b0;
    repeat (50) @(negedge clk);
    idle_bits(2);
    total++; if (dv_q.size() - dv0 !== 0) begin bad++; $display("FAIL glitch_dv: got %0d need 0", dv_q.size() - dv0); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL glitch_frame_err: got %0d need 0", fe_cnt - fe0); end
    total++; if (tx_low_cnt - tl0 !== 0) begin bad++; $display("FAIL glitch_tx_low: got %0d need 0", tx_low_cnt - tl0); end
    total++; if (ack_busy !== 1'b0) begin bad++; $display("FAIL glitch_ack_busy: got %b need 0", ack_busy); end
  endtask

  task automatic test_frame_err();
    int dv0, ak0, fe0;
    dv0 = dv_q.size(); ak0 = ack_q.size(); fe0 = fe_cnt;
    send_frame(8'h2F, 1'b0);
    rx = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    idle_bits(1);
    total++; if (ack_busy !== 1'b0) begin bad++; $display("FAIL ferr_no_ack_busy: got %b need 0", ack_busy); end
    send_frame(8'h3F, 1'b1);
    idle_bits(1);
    wait_idle("ferr");
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL ferr_count: got %0d need 1", fe_cnt - fe0); end
    total++; if (dv_q.size() - dv0 !== 1) begin bad++; $display("FAIL ferr_dv_count: got %0d need 1", dv_q.size() - dv0); end
    if (dv_q.size() > dv0) begin
      total++; if (dv_q[dv0] !== 8'h3F) begin bad++; $display("FAIL ferr_dv_byte: got %h need 3f", dv_q[dv0]); end
    end
    total++; if (ack_q.size() - ak0 !== 1) begin bad++; $display("FAIL ferr_ack_count: got %0d need 1", ack_q.size() - ak0); end
    if (ack_q.size() > ak0) begin
      total++; if (ack_q[ak0] !== ACK) begin bad++; $display("FAIL ferr_ack_byte: got %h need cc", ack_q[ak0]); end
    end
  endtask

  task automatic test_back_to_back();
    int dv0, ak0;
    dv0 = dv_q.size(); ak0 = ack_q.size();
    send_frame(8'h2F, 1'b1);
    send_frame(8'h3F, 1'b1);
    idle_bits(1);
    wait_idle("b2b");
    total++; if (dv_q.size() - dv0 !== 2) begin bad++; $display("FAIL b2b_dv_count: got %0d need 2", dv_q.size() - dv0); end
    if (dv_q.size() > dv0 + 1) begin
      total++; if (dv_q[dv0] !== 8'h2F) begin bad++; $display("FAIL b2b_dv0: got %h need 2f", dv_q[dv0]); end
      total++; if (dv_q[dv0+1] !== 8'h3F) begin bad++; $display("FAIL b2b_dv1: got %h need 3f", dv_q[dv0+1]); end
    end
    total++; if (data_out !== 8'h3F) begin bad++; $display("FAIL b2b_data_out: got %h need 3f", data_out); end
    total++; if (ack_q.size() - ak0 !== 2) begin bad++; $display("FAIL b2b_ack_count: got %0d need 2", ack_q.size() - ak0); end
    if (ack_q.size() > ak0 + 1) begin
      total++; if (ack_q[ak0] !== ACK || ack_q[ak0+1] !== ACK) begin
        bad++; $display("FAIL b2b_ack_bytes: got %h %h need cc cc", ack_q[ak0], ack_q[ak0+1]);
      end
      total++; if (ack_start_q[ak0+1] - ack_start_q[ak0] < 10 * BAUD) begin
        bad++; $display("FAIL b2b_ack_overlap: got gap %0d need >= %0d", ack_start_q[ak0+1] - ack_start_q[ak0], 10 * BAUD);
      end
    end
    total++; if (stop_bad !== 0) begin bad++; $display("FAIL b2b_ack_framing: got %0d need 0", stop_bad); end
  endtask

  task automatic test_duplicate();
    int dv0, ak0;
    dv0 = dv_q.size(); ak0 = ack_q.size();
    send_frame(8'h05, 1'b1);
    idle_bits(2);
    send_frame(8'h05, 1'b1);
    idle_bits(1);
    wait_idle("dup");
    total++; if (dv_q.size() - dv0 !== 2) begin bad++; $display("FAIL dup_dv_count: got %0d need 2", dv_q.size() - dv0); end
    if (dv_q.size() > dv0 + 1) begin
      total++; if (dv_q[dv0] !== 8'h05 || dv_q[dv0+1] !== 8'h05) begin
        bad++; $display("FAIL dup_dv_bytes: got %h %h need 05 05", dv_q[dv0], dv_q[dv0+1]);
      end
    end
    total++; if (ack_q.size() - ak0 !== 2) begin bad++; $display("FAIL dup_ack_count: got %0d need 2", ack_q.size() - ak0); end
  endtask

  task automatic test_reset_mid();
    int dv0, dv1, ak1;
    logic [7:0] part;
    part = 8'hC3;
    send_frame(8'h5A, 1'b1);
    dv0 = dv_q.size();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(part[i]);
    rx = part[4];
    repeat (HALF) @(negedge clk);
    total++; if (ack_busy !== 1'b1) begin bad++; $display("FAIL rstmid_ack_active: got %b need 1", ack_busy); end
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b need 1", tx); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rstmid_data_out: got %h need 00", data_out); end
    total++; if (ack_busy !== 1'b0) begin bad++; $display("FAIL rstmid_ack_busy: got %b need 0", ack_busy); end
    rst = 1'b0;
    idle_bits(12);
    total++; if (dv_q.size() - dv0 !== 0) begin bad++; $display("FAIL rstmid_aborted_dv: got %0d need 0", dv_q.size() - dv0); end
    dv1 = dv_q.size(); ak1 = ack_q.size();
    send_frame(8'hA5, 1'b1);
    idle_bits(1);
    wait_idle("rstmid");
    total++; if (dv_q.size() - dv1 !== 1) begin bad++; $display("FAIL rstmid_dv_count: got %0d need 1", dv_q.size() - dv1); end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL rstmid_data_out_after: got %h need a5", data_out); end
    total++; if (ack_q.size() - ak1 !== 1) begin bad++; $display("FAIL rstmid_ack_count: got %0d need 1", ack_q.size() - ak1); end
    if (ack_q.size() > ak1) begin
      total++; if (ack_q[ak1] !== ACK) begin bad++; $display("FAIL rstmid_ack_byte: got %h need cc", ack_q[ak1]); end
    end
  endtask

  task automatic test_random();
    int dv0, ak0, fe0;
    logic [7:0] d;
    logic good;
    dv0 = dv_q.size(); ak0 = ack_q.size(); fe0 = fe_cnt;
    exp_q.delete();
    exp_fe = 0;
    for (int n = 0; n < 6; n++) begin
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      send_frame(d, good);
      if (good) begin
        exp_q.push_back(d);
        idle_bits($urandom_range(0, 2));
      end else begin
        exp_fe++;
        idle_bits($urandom_range(1, 2));
      end
    end
    idle_bits(1);
    wait_idle("rand");
    total++; if (dv_q.size() - dv0 !== exp_q.size()) begin
      bad++; $display("FAIL rand_dv_count: got %0d need %0d", dv_q.size() - dv0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (dv0 + k < dv_q.size()) begin
        total++; if (dv_q[dv0+k] !== exp_q[k]) begin
          bad++; $display("FAIL rand_dv_byte%0d: got %h need %h", k, dv_q[dv0+k], exp_q[k]);
        end
      end
    end
    total++; if (fe_cnt - fe0 !== exp_fe) begin bad++; $display("FAIL rand_frame_err: got %0d need %0d", fe_cnt - fe0, exp_fe); end
    total++; if (ack_q.size() - ak0 !== exp_q.size()) begin
      bad++; $display("FAIL rand_ack_count: got %0d need %0d", ack_q.size() - ak0, exp_q.size());
    end
    for (int k = ak0; k < ack_q.size(); k++) begin
      total++; if (ack_q[k] !== ACK) begin bad++; $display("FAIL rand_ack_byte%0d: got %h need cc", k - ak0, ack_q[k]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_duplicate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
